// File: rtl/spu_simd_shift_rotate_unit_if.sv
// Handshake and data bundle for the SPU SIMD shift/rotate unit.
// A transfer happens on a rising edge where valid && ready. The producer holds valid and data stable until the transfer completes, and ready may depend combinationally on the consumer's ready.
interface spu_simd_shift_rotate_unit_if #(
  parameter int WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic             use_imm;
  logic [6:0]       imm7;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rt;

  modport master (
    output in_valid, op, use_imm, imm7, ra, rb, out_ready,
    input  in_ready, out_valid, rt
  );

  modport slave (
    input  in_valid, op, use_imm, imm7, ra, rb, out_ready,
    output in_ready, out_valid, rt
  );
endinterface

// File: rtl/spu_simd_shift_rotate_unit.sv
// Pipelined SIMD shift/rotate unit (SHL, ROT, SHR, SRA) with a STAGES-deep stalling pipeline.
// Define SPU_SHIFT_ARITH_EN to make op 11 an arithmetic right shift; otherwise op 11 is a logical right shift.
module spu_simd_shift_rotate_unit #(
  parameter int WIDTH  = 128,
  parameter int ELEM_W = 16,
  parameter int STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  spu_simd_shift_rotate_unit_if.slave    io,
  output logic [STAGES-1:0]              dbg_stage_valid
);

  localparam int N  = WIDTH / ELEM_W;
  localparam int LG = $clog2(ELEM_W);

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_ROT = 2'b01;
`ifdef SPU_SHIFT_ARITH_EN
  localparam logic [1:0] OP_SRA = 2'b11;
`endif

  logic [ELEM_W-1:0] imm_ext;
  logic [WIDTH-1:0]  result;

  assign imm_ext = {{(ELEM_W-7){io.imm7[6]}}, io.imm7};

  // Per-element datapath. Counts are reduced to LG+1 bits; the top bit marks "shifted fully out".
  for (genvar i = 0; i < N; i++) begin : g_elem
    logic [ELEM_W-1:0]   x;
    logic [ELEM_W-1:0]   cnt;
    logic [ELEM_W-1:0]   neg_cnt;
    logic [LG:0]         n_l;
    logic [LG:0]         n_r;
    logic [2*ELEM_W-1:0] dbl;
    logic [ELEM_W-1:0]   elem_res;
    logic                unused_cnt_bits;

    always_comb begin
      x        = io.ra[i*ELEM_W +: ELEM_W];
      cnt      = io.use_imm ? imm_ext : io.rb[i*ELEM_W +: ELEM_W];
      neg_cnt  = '0 - cnt;
      n_l      = cnt[LG:0];
      n_r      = neg_cnt[LG:0];
      dbl      = {x, x} << n_l[LG-1:0];
      elem_res = '0;
      case (io.op)
        OP_SHL: elem_res = n_l[LG] ? '0 : (x << n_l[LG-1:0]);
        OP_ROT: elem_res = dbl[2*ELEM_W-1 -: ELEM_W];
`ifdef SPU_SHIFT_ARITH_EN
        OP_SRA: elem_res = n_r[LG] ? {ELEM_W{x[ELEM_W-1]}}
                                   : ELEM_W'($signed(x) >>> n_r[LG-1:0]);
`endif
        default: elem_res = n_r[LG] ? '0 : (x >> n_r[LG-1:0]);
      endcase
    end

    assign unused_cnt_bits = ^{cnt[ELEM_W-1:LG+1], neg_cnt[ELEM_W-1:LG+1]};
    assign result[i*ELEM_W +: ELEM_W] = elem_res;
  end

  // Pipeline: stage 0 captures the computed result, later stages only hold it.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] adv;
  logic              accept;
  logic              chain;

  always_comb begin
    adv   = '0;
    chain = !vld_q[STAGES-1] || io.out_ready;
    adv[STAGES-1] = chain;
    // Walk from the output back so each stage sees whether its successor frees a slot.
    for (int k = STAGES - 2; k >= 0; k--) begin
      chain  = !vld_q[k] || chain;
      adv[k] = chain;
    end
    accept = io.in_valid && adv[0];
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (adv[0]) begin
      vld_d[0] = accept;
      if (accept) begin
        data_d[0] = result;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          data_d[k] = data_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign io.in_ready   = adv[0];
  assign io.out_valid  = vld_q[STAGES-1];
  assign io.rt         = data_q[STAGES-1];
  assign dbg_stage_valid = vld_q;

endmodule

// File: tb/tb_spu_simd_shift_rotate_unit.sv
// Bench for spu_simd_shift_rotate_unit: directed cases plus randomized traffic against a bit-level reference model.
module tb_spu_simd_shift_rotate_unit;

  localparam int WIDTH  = 128;
  localparam int ELEM_W = 16;
  localparam int STAGES = 2;
  localparam int N      = WIDTH / ELEM_W;
`ifdef SPU_SHIFT_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [STAGES-1:0] dbg_stage_valid;

  spu_simd_shift_rotate_unit_if #(.WIDTH(WIDTH)) io ();

  spu_simd_shift_rotate_unit #(
    .WIDTH (WIDTH),
    .ELEM_W(ELEM_W),
    .STAGES(STAGES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .io             (io),
    .dbg_stage_valid(dbg_stage_valid)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  bit bp_en = 1'b0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [ELEM_W-1:0] ref_elem(input logic [1:0] op_i, input logic [ELEM_W-1:0] x, input int cnt);
    logic [ELEM_W-1:0] r;
    int n;
    r = '0;
    if (op_i == 2'd0) begin
      n = cnt % (2 * ELEM_W);
      for (int j = 0; j < ELEM_W; j++)
        if (n < ELEM_W && j >= n) r[j] = x[j - n];
    end else if (op_i == 2'd1) begin
      n = cnt % ELEM_W;
      for (int j = 0; j < ELEM_W; j++) r[j] = x[(j - n + ELEM_W) % ELEM_W];
    end else begin
      n = (2 * ELEM_W - (cnt % (2 * ELEM_W))) % (2 * ELEM_W);
      for (int j = 0; j < ELEM_W; j++) begin
        if (j + n < ELEM_W) r[j] = x[j + n];
        else if (op_i == 2'd3 && ARITH) r[j] = x[ELEM_W - 1];
        else r[j] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] ref_vec(input logic [1:0] op_i, input logic use_imm_i, input logic [6:0] imm_i,
                                               input logic [WIDTH-1:0] ra_i, input logic [WIDTH-1:0] rb_i);
    logic [WIDTH-1:0] v;
    int modv;
    int s;
    int cnt;
    modv = 1 << ELEM_W;
    s = imm_i[6] ? int'(imm_i) - 128 : int'(imm_i);
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (use_imm_i) cnt = ((s % modv) + modv) % modv;
      else cnt = int'(rb_i[i*ELEM_W +: ELEM_W]);
      v[i*ELEM_W +: ELEM_W] = ref_elem(op_i, ra_i[i*ELEM_W +: ELEM_W], cnt);
    end
    return v;
  endfunction

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic send_op(input logic [1:0] op_i, input logic use_imm_i, input logic [6:0] imm_i,
                         input logic [WIDTH-1:0] ra_i, input logic [WIDTH-1:0] rb_i, input logic [WIDTH-1:0] exp_i);
    int waited = 0;
    bit ok = 1'b0;
    io.in_valid = 1'b1;
    io.op       = op_i;
    io.use_imm  = use_imm_i;
    io.imm7     = imm_i;
    io.ra       = ra_i;
    io.rb       = rb_i;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (io.in_ready) ok = 1'b1;
      else waited++;
    end
    if (ok) begin
      exp_q.push_back(exp_i);
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout waited=%0d cycles required=accept", waited);
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.op       = 2'($urandom_range(0, 3));
    io.imm7     = 7'($urandom_range(0, 127));
    io.ra       = {4{$urandom}};
  endtask

  task automatic send_model(input logic [1:0] op_i, input logic use_imm_i, input logic [6:0] imm_i,
                            input logic [WIDTH-1:0] ra_i, input logic [WIDTH-1:0] rb_i);
    send_op(op_i, use_imm_i, imm_i, ra_i, rb_i, ref_vec(op_i, use_imm_i, imm_i, ra_i, rb_i));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- backpressure generator ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) io.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (io.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output rt=%h required=no output", io.rt);
      end else begin
        check("rt", io.rt, exp_q[0]);
        if (io.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  logic [WIDTH-1:0] rb_pat;
  logic [WIDTH-1:0] exp_pat;
  logic [15:0] cnt_tab [4];
  logic [15:0] res_tab [4];
  int lat;
  int waited;

  initial begin
    cnt_tab = '{16'h0000, 16'hFFFF, 16'hFFF1, 16'hFFF0};
    res_tab = '{16'hF00F, 16'h7807, 16'h0001, 16'h0000};
    for (int i = 0; i < N; i++) begin
      rb_pat[i*ELEM_W +: ELEM_W]  = cnt_tab[i % 4];
      exp_pat[i*ELEM_W +: ELEM_W] = res_tab[i % 4];
    end

    rst_n = 1'b0;
    io.in_valid = 1'b0; io.op = 2'b00; io.use_imm = 1'b0; io.imm7 = '0;
    io.ra = '0; io.rb = '0; io.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", WIDTH'(io.out_valid), '0);
    check("reset_rt", io.rt, '0);
    check("reset_in_ready", WIDTH'(io.in_ready), WIDTH'(1));
    check("reset_dbg_valid", WIDTH'(dbg_stage_valid), '0);
    @(posedge clk); #1;

    // Directed cases with hand-derived results
    send_op(2'b00, 1'b1, 7'd3, {N{16'h8001}}, '0, {N{16'h0008}});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!io.out_valid && lat < 20);
    check("latency", WIDTH'(lat), WIDTH'(STAGES));
    @(posedge clk); #1;
    send_op(2'b00, 1'b1, 7'd16, {N{16'hFFFF}}, '0, {N{16'h0000}});
    send_op(2'b01, 1'b1, 7'd4,  {N{16'h1234}}, '0, {N{16'h2341}});
    send_op(2'b01, 1'b1, 7'd20, {N{16'h1234}}, '0, {N{16'h2341}});
    send_op(2'b10, 1'b1, 7'h7F, {N{16'h8000}}, '0, {N{16'h4000}});
    send_op(2'b10, 1'b0, 7'd0,  {N{16'hF00F}}, rb_pat, exp_pat);
`ifdef SPU_SHIFT_ARITH_EN
    send_op(2'b11, 1'b1, 7'h7F, {N{16'h8000}}, '0, {N{16'hC000}});
    send_op(2'b11, 1'b1, 7'h70, {N{16'h8000}}, '0, {N{16'hFFFF}});
`else
    send_op(2'b11, 1'b1, 7'h7F, {N{16'h8000}}, '0, {N{16'h4000}});
    send_op(2'b11, 1'b1, 7'h70, {N{16'h8000}}, '0, {N{16'h0000}});
`endif
    idle(4);

    // Backpressure: two ops fill the pipe, the third must wait
    io.out_ready = 1'b0;
    send_op(2'b01, 1'b1, 7'd1, {N{16'hA001}}, '0, {N{16'h4003}});
    send_op(2'b01, 1'b1, 7'd2, {N{16'hA001}}, '0, {N{16'h8006}});
    io.in_valid = 1'b1; io.op = 2'b01; io.use_imm = 1'b1; io.imm7 = 7'd3;
    io.ra = {N{16'hA001}};
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", WIDTH'(io.in_ready), '0);
    end
    @(posedge clk); #1;
    io.out_ready = 1'b1;
    send_op(2'b01, 1'b1, 7'd3, {N{16'hA001}}, '0, {N{16'h000D}});
    repeat (2) begin
      @(negedge clk);
      check("drain_back_to_back", WIDTH'(io.out_valid), WIDTH'(1));
    end
    @(posedge clk); #1;
    idle(3);

    // Asynchronous reset with two results in flight
    io.out_ready = 1'b0;
    send_model(2'b00, 1'b1, 7'd1, {N{16'h1111}}, '0);
    send_model(2'b00, 1'b1, 7'd2, {N{16'h2222}}, '0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", WIDTH'(io.out_valid), '0);
    check("async_rst_rt", io.rt, '0);
    exp_q.delete();
    io.out_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", WIDTH'(io.in_ready), WIDTH'(1));
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_output", WIDTH'(io.out_valid), '0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and bubbles
    bp_en = 1'b1;
    for (int t = 0; t < 300; t++) begin
      send_model(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                 {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    bp_en = 1'b0;
    @(posedge clk); #1;
    io.out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    check("drain_complete", WIDTH'(exp_q.size()), '0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spu_simd_shift_rotate_unit.md
# spu_simd_shift_rotate_unit

Parametrised, pipelined SIMD shift/rotate execution unit for the SPU even pipe. It generalises the halfword-immediate left shift to any element width, to register or immediate counts, and to left-shift, rotate, logical-right and (optionally) arithmetic-right modes. A valid/ready handshake carries results through a STAGES-deep stalling register pipeline.

## Interface
- WIDTH, 128, vector width in bits; must be a multiple of ELEM_W
- ELEM_W, 16, element width in bits (8, 16, 32 or 64; power of two)
- STAGES, 2, pipeline depth in registers (1..4); equals latency
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts operation this cycle
- op  in  2  00 SHL, 01 ROT, 10 SHR (logical, rotate-and-mask), 11 SRA
- use_imm  in  1  1: count from imm7 for every element; 0: count from matching rb element
- imm7  in  7  signed immediate count
- ra  in  WIDTH  source vector
- rb  in  WIDTH  per-element count vector
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- rt  out  WIDTH  result vector

## Operation
- Element i occupies bits [i*ELEM_W +: ELEM_W]; N = WIDTH/ELEM_W elements processed independently.
- Count source c: use_imm=1 → imm7 sign-extended to ELEM_W; use_imm=0 → rb element i. All arithmetic modulo 2^ELEM_W.
- SHL: n = c & (2*ELEM_W-1); n >= ELEM_W → 0, else x << n, zero fill.
- ROT: n = c & (ELEM_W-1); rotate left by n.
- SHR: n = (-c) & (2*ELEM_W-1); n >= ELEM_W → 0, else x >> n, zero fill.
- SRA: n as SHR; n >= ELEM_W → all bits = x MSB, else arithmetic right shift (see Configuration).
- Result computed combinationally from accepted inputs and written into pipeline stage 0; stages 1..STAGES-1 are pure holding registers. rt/out_valid driven from last stage.
- Accept (handshake) when in_valid && in_ready; emit when out_valid && out_ready.
- Pipeline stall: stage k advances when stage k+1 is empty or advancing; last stage advances when empty or out_ready. in_ready = stage 0 empty or stage 0 advancing (combinational from out_ready through the chain).
- Bubbles collapse: an empty stage is filled regardless of downstream stall.
- Order strictly preserved; no result dropped or duplicated.
- op, use_imm, imm7, ra, rb sampled only on accept; changes while in_ready=0 ignored.

## Timing
- Reset (rst_n low, async): all stage valid bits 0, all stage data 0; out_valid=0, rt=0, in_ready=1 after release.
- Reset mid-operation discards all in-flight results; no output after release until new accept.
- Latency: accept at edge t → out_valid at edge t+STAGES-1 (visible following cycle), i.e. STAGES cycles, with out_ready held 1.
- Throughput 1 op/cycle with out_ready=1; simultaneous accept and emit in the same cycle when full is allowed.
- Capacity STAGES results; in_ready=0 only when all stages full and out_ready=0.
- rt holds stable while out_valid=1 and out_ready=0.
- in_valid=0 cycles insert bubbles; out_valid deasserts when last stage drains.

## Configuration
- SPU_SHIFT_ARITH_EN defined: op 11 performs SRA as specified.
- Not defined: op 11 behaves exactly as SHR (logical, zero fill); no sign-extension logic compiled.

## Test plan
- ELEM_W=16, op=SHL, use_imm=1, imm7=3, all ra elements 16'h8001 → every rt element 16'h0008 after 2 cycles (STAGES=2).
- SHL imm7=16 on 16'hFFFF → 16'h0000; ROT imm7=4 on 16'h1234 → 16'h2341; ROT imm7=20 → also 16'h2341.
- SHR use_imm=1 imm7=7'h7F (−1) on 16'h8000 → 16'h4000; use_imm=0 with rb elements 0,−1,−15,−16 on 16'hF00F → F00F, 7807, 0001, 0000.
- SRA imm7=7'h7F on 16'h8000: with SPU_SHIFT_ARITH_EN → 16'hC000; without → 16'h4000; SRA count −16 on 16'h8000 (macro on) → 16'hFFFF.
- Backpressure, STAGES=2: out_ready=0, offer ops A,B,C back-to-back → A,B accepted, in_ready=0 while C held; raise out_ready → outputs A,B,C in order, one per cycle, rt stable during stall.
- Assert rst_n low asynchronously with 2 results in flight → out_valid and rt 0 immediately; after release no output until new accept, in_ready=1.
